// File: rtl/even_parity_check_if.sv
// even_parity_check_if
// Bundles the signals of the even-parity checker.
//   master : drives data_in, parity_in, in_valid and clear, and observes the status outputs
//   slave  : the checker; it drives error, parity_out, error_q, error_sticky and the counters
// Signals:
//   data_in      [DATA_W] data word under check
//   parity_in    [1]      received even-parity bit
//   in_valid     [1]      qualifies the word for the registered monitor path
//   clear        [1]      synchronous clear of the sticky flag and the counters
//   error        [1]      combinational parity error
//   parity_out   [1]      generated even-parity bit for data_in
//   error_q      [1]      registered error, captured on valid cycles
//   error_sticky [1]      sticky error flag
//   check_count  [CNT_W]  saturating count of valid words
//   error_count  [CNT_W]  saturating count of valid erroneous words
interface even_parity_check_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] data_in;
  logic              parity_in;
  logic              in_valid;
  logic              clear;
  logic              error;
  logic              parity_out;
  logic              error_q;
  logic              error_sticky;
  logic [CNT_W-1:0]  check_count;
  logic [CNT_W-1:0]  error_count;

  modport master (
    output data_in, parity_in, in_valid, clear,
    input  error, parity_out, error_q, error_sticky, check_count, error_count
  );

  modport slave (
    input  data_in, parity_in, in_valid, clear,
    output error, parity_out, error_q, error_sticky, check_count, error_count
  );
endinterface

// File: rtl/even_parity_check.sv
// even_parity_check
// Even-parity checker on the receive side of a parallel link. The error flag and
// the generated parity bit are purely combinational; a registered monitor path keeps
// a sampled error flag, a sticky error flag and saturating check/error counters for
// the control/CSR logic.
// Ports:
//   clk  : system clock, state updates on the rising edge
//   rst  : asynchronous active-high reset, clears all registered state at once
//   bus  : even_parity_check_if slave modport (data, parity, valid, clear in;
//          error, parity_out, error_q, error_sticky, check_count, error_count out)
module even_parity_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  even_parity_check_if.slave bus
);

  // Counter increment that stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              parity_p0;
  logic              err_p0;
  logic              vld_p0;
  logic              clr_p0;

  logic              err_q_p1;
  logic              sticky_p1;
  logic [CNT_W-1:0]  chk_cnt_p1;
  logic [CNT_W-1:0]  err_cnt_p1;

  // Stage 0: combinational parity generation and check.
  assign parity_p0 = ^bus.data_in;
  assign err_p0    = parity_p0 ^ bus.parity_in;
  assign vld_p0    = bus.in_valid;
  assign clr_p0    = bus.clear;

  // Stage 1: monitor registers. error_q follows any valid word, even when a clear
  // in the same cycle suppresses counting of that word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q_p1 <= 1'b0;
    end else if (vld_p0) begin
      err_q_p1 <= err_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_p1  <= 1'b0;
      chk_cnt_p1 <= '0;
      err_cnt_p1 <= '0;
    end else if (clr_p0) begin
      sticky_p1  <= 1'b0;
      chk_cnt_p1 <= '0;
      err_cnt_p1 <= '0;
    end else if (vld_p0) begin
      sticky_p1  <= sticky_p1 | err_p0;
      chk_cnt_p1 <= sat_inc(chk_cnt_p1);
      if (err_p0) begin
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

  assign bus.parity_out   = parity_p0;
  assign bus.error        = err_p0;
  assign bus.error_q      = err_q_p1;
  assign bus.error_sticky = sticky_p1;
  assign bus.check_count  = chk_cnt_p1;
  assign bus.error_count  = err_cnt_p1;

endmodule

// File: tb/tb_even_parity_check.sv
module tb_even_parity_check;
  localparam int DW    = 8;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  even_parity_check_if #(.DATA_W(DW), .CNT_W(16)) bus_a ();
  even_parity_check_if #(.DATA_W(DW), .CNT_W(2))  bus_b ();

  even_parity_check #(.DATA_W(DW), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  even_parity_check #(.DATA_W(DW), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    bit         at_edge;
    string      tag;
    logic       exp_err;
    logic       exp_pout;
    logic       exp_q;
    logic       exp_st;
    int         exp_ca;
    int         exp_ea;
    int         exp_cb;
    int         exp_eb;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state, kept as plain integers.
  int   m_ca = 0, m_ea = 0, m_cb = 0, m_eb = 0;
  logic m_q  = 1'b0, m_st = 1'b0;
  logic [DW-1:0] cur_d = '0;
  logic          cur_p = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic p, input logic v, input logic c);
    bus_a.data_in = d; bus_a.parity_in = p; bus_a.in_valid = v; bus_a.clear = c;
    bus_b.data_in = d; bus_b.parity_in = p; bus_b.in_valid = v; bus_b.clear = c;
    cur_d = d; cur_p = p;
  endtask

  function automatic rec_t mk(input bit at_edge, input string tag, input int force_err);
    rec_t r;
    r.at_edge  = at_edge;
    r.tag      = tag;
    r.exp_pout = logic'($countones(cur_d) % 2);
    r.exp_err  = (force_err >= 0) ? logic'(force_err) : logic'(($countones(cur_d) + int'(cur_p)) % 2);
    r.exp_q    = m_q;
    r.exp_st   = m_st;
    r.exp_ca   = m_ca; r.exp_ea = m_ea; r.exp_cb = m_cb; r.exp_eb = m_eb;
    return r;
  endfunction

  // One clock of stimulus: drive at the falling edge, advance the model, queue the expectation.
  task automatic step(input logic [DW-1:0] d, input logic p, input logic v, input logic c,
                      input string tag, input int force_err = -1);
    logic e;
    drive(d, p, v, c);
    e = logic'(($countones(d) + int'(p)) % 2);
    if (v) m_q = e;
    if (c) begin
      m_st = 1'b0; m_ca = 0; m_ea = 0; m_cb = 0; m_eb = 0;
    end else if (v) begin
      m_st = m_st | e;
      m_ca = (m_ca < MAX_A) ? m_ca + 1 : MAX_A;
      m_cb = (m_cb < MAX_B) ? m_cb + 1 : MAX_B;
      if (e) begin
        m_ea = (m_ea < MAX_A) ? m_ea + 1 : MAX_A;
        m_eb = (m_eb < MAX_B) ? m_eb + 1 : MAX_B;
      end
    end
    q.push_back(mk(1'b1, tag, force_err));
    wait (q.size() == 0);
    @(negedge clk);
  endtask

  // Monitor: compares each queued expectation after the edge it refers to
  // (or immediately for an asynchronous event).
  initial begin
    rec_t r;
    forever begin
      wait (q.size() > 0);
      if (q[0].at_edge) begin
        @(posedge clk);
        #1;
      end else begin
        #1;
      end
      r = q.pop_front();
      chk({r.tag, ".error"},        32'(bus_a.error),        32'(r.exp_err));
      chk({r.tag, ".parity_out"},   32'(bus_a.parity_out),   32'(r.exp_pout));
      chk({r.tag, ".error_q"},      32'(bus_a.error_q),      32'(r.exp_q));
      chk({r.tag, ".error_sticky"}, 32'(bus_a.error_sticky), 32'(r.exp_st));
      chk({r.tag, ".check_count"},  32'(bus_a.check_count),  32'(r.exp_ca));
      chk({r.tag, ".error_count"},  32'(bus_a.error_count),  32'(r.exp_ea));
      chk({r.tag, ".w2.error"},     32'(bus_b.error),        32'(r.exp_err));
      chk({r.tag, ".w2.error_q"},   32'(bus_b.error_q),      32'(r.exp_q));
      chk({r.tag, ".w2.sticky"},    32'(bus_b.error_sticky), 32'(r.exp_st));
      chk({r.tag, ".w2.check_count"}, 32'(bus_b.check_count), 32'(r.exp_cb));
      chk({r.tag, ".w2.error_count"}, 32'(bus_b.error_count), 32'(r.exp_eb));
      chk({r.tag, ".invariant"},    32'(bus_a.error_count <= bus_a.check_count), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [DW-1:0] vec_d [7] = '{8'h00, 8'h01, 8'h02, 8'hA6, 8'h0E, 8'hD9, 8'hE8};
  logic          vec_p [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int            vec_e [7] = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    // Reset held across an edge: everything registered reads zero.
    drive('0, 1'b0, 1'b1, 1'b0);
    q.push_back(mk(1'b1, "reset", -1));
    wait (q.size() == 0);
    @(negedge clk);
    rst = 1'b0;

    // The seven listed vectors on consecutive edges.
    for (int i = 0; i < 7; i++) step(vec_d[i], vec_p[i], 1'b1, 1'b0, $sformatf("vec%0d", i), vec_e[i]);

    // Clear together with a valid erroneous word.
    step(8'h00, 1'b1, 1'b1, 1'b1, "clear_prio", 1);

    // Build some state, then hold erroneous data with in_valid low.
    step(8'h01, 1'b0, 1'b1, 1'b0, "pre_idle", 1);
    step(8'h02, 1'b1, 1'b1, 1'b0, "pre_idle_ok", 0);
    for (int i = 0; i < 5; i++) step(8'h07, 1'b0, 1'b0, 1'b0, $sformatf("idle%0d", i), 1);

    // Saturation of the narrow-counter instance.
    step(8'h00, 1'b0, 1'b1, 1'b1, "sat_clear", 0);
    for (int i = 0; i < 6; i++) step(8'h80, 1'b0, 1'b1, 1'b0, $sformatf("sat%0d", i), 1);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      logic [DW-1:0] d;
      logic p, v, c;
      d = DW'($urandom);
      p = 1'($urandom % 2);
      v = ($urandom % 4) != 0;
      c = ($urandom % 25) == 0;
      step(d, p, v, c, "rand");
    end

    // Accumulate errors, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) step(8'h0B, 1'b0, 1'b1, 1'b0, "pre_rst", 1);
    #2;
    rst = 1'b1;
    m_q = 1'b0; m_st = 1'b0; m_ca = 0; m_ea = 0; m_cb = 0; m_eb = 0;
    q.push_back(mk(1'b0, "async_rst", -1));
    wait (q.size() == 0);
    @(negedge clk);
    rst = 1'b0;
    step(8'h03, 1'b1, 1'b1, 1'b0, "post_rst0", 1);
    step(8'h03, 1'b0, 1'b1, 1'b0, "post_rst1", 0);

    wait (q.size() == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
